// File: rtl/calc_pkg.sv
// Shared opcode and FSM state types for the accumulator calculator.
package calc_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_EQ   = 3'b101,
    OP_MUL  = 3'b110,
    OP_LOAD = 3'b111
  } calc_op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } calc_state_t;

  localparam int CALC_WIDTH_MIN = 4;
  localparam int CALC_WIDTH_MAX = 32;

endpackage

// File: rtl/calc_mul_seq.sv
// Sequential shift-add multiplier: one partial product per cycle, WIDTH cycles per multiply.
// o_done/o_product describe the step completing at the coming edge, so the parent can register them on that edge.
module calc_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic                 i_abort,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [2*WIDTH-1:0]   o_product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH:0]   w_sum;

  // r_lo holds the unconsumed multiplier bits in its low end and product bits shifted in from the top.
  assign w_sum     = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
  assign o_busy    = (r_count != '0);
  assign o_done    = (r_count == CW'(1)) && !i_abort;
  assign o_product = {w_sum, r_lo[WIDTH-1:1]};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
      r_a     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else if (i_abort) begin
      r_count <= '0;
    end else if (i_start) begin
      r_a     <= i_a;
      r_hi    <= '0;
      r_lo    <= i_b;
      r_count <= CW'(WIDTH);
    end else if (o_busy) begin
      r_hi    <= w_sum[WIDTH:1];
      r_lo    <= {w_sum[0], r_lo[WIDTH-1:1]};
      r_count <= r_count - CW'(1);
    end
  end

endmodule

// File: rtl/calc_accumulator.sv
// WIDTH-bit accumulator calculator with valid/ready command input, status flags and an optional
// multi-cycle multiply; owns the FSM, ALU and handshake.
module calc_accumulator
  import calc_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int MUL_EN = 1
) (
  input  logic             clock,
  input  logic             Reset_n,
  input  logic [WIDTH-1:0] NumIn,
  input  logic [2:0]       OpIn,
  input  logic             Enter,
  input  logic             Clear,
  output logic             Ready,
  output logic [WIDTH-1:0] NumOut,
  output logic             Done,
  output logic             Carry,
  output logic             Overflow,
  output logic             Zero
);

  generate
    if (WIDTH < CALC_WIDTH_MIN || WIDTH > CALC_WIDTH_MAX) begin : g_bad_width
      $error("calc_accumulator: WIDTH must be in 4..32");
    end
  endgenerate

  calc_state_t r_state;
  calc_state_t w_state_next;

  logic [WIDTH-1:0]   r_acc;
  logic               r_done;
  logic               r_carry;
  logic               r_ovf;
  logic               r_zero;

  calc_op_t           w_op;
  logic               w_accept;
  logic               w_is_mul;
  logic               w_mul_start;
  logic               w_mul_busy;
  logic               w_mul_done;
  logic [2*WIDTH-1:0] w_product;
  logic [WIDTH:0]     w_add;
  logic [WIDTH:0]     w_sub;
  logic [WIDTH-1:0]   w_res;
  logic               w_carry;
  logic               w_ovf;

  assign w_op        = calc_op_t'(OpIn);
  // Clear wins over a same-cycle command, which is dropped rather than queued.
  assign w_accept    = Enter && (r_state == ST_IDLE) && !Clear;
  assign w_is_mul    = (w_op == OP_MUL) && (MUL_EN != 0);
  assign w_mul_start = w_accept && w_is_mul;

  generate
    if (MUL_EN != 0) begin : g_mul
      calc_mul_seq #(
        .WIDTH(WIDTH)
      ) u_mul (
        .i_clk     (clock),
        .i_rst_n   (Reset_n),
        .i_start   (w_mul_start),
        .i_abort   (Clear),
        .i_a       (r_acc),
        .i_b       (NumIn),
        .o_busy    (w_mul_busy),
        .o_done    (w_mul_done),
        .o_product (w_product)
      );
    end else begin : g_no_mul
      assign w_mul_busy = 1'b0;
      assign w_mul_done = 1'b0;
      assign w_product  = '0;
    end
  endgenerate

  assign w_add = {1'b0, r_acc} + {1'b0, NumIn};
  assign w_sub = {1'b0, r_acc} - {1'b0, NumIn};

  always_comb begin
    w_res   = r_acc;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    case (w_op)
      OP_ADD: begin
        w_res   = w_add[WIDTH-1:0];
        w_carry = w_add[WIDTH];
        w_ovf   = (r_acc[WIDTH-1] == NumIn[WIDTH-1]) && (w_add[WIDTH-1] != r_acc[WIDTH-1]);
      end
      OP_SUB: begin
        w_res   = w_sub[WIDTH-1:0];
        w_carry = w_sub[WIDTH];
        w_ovf   = (r_acc[WIDTH-1] != NumIn[WIDTH-1]) && (w_sub[WIDTH-1] != r_acc[WIDTH-1]);
      end
      OP_AND:  w_res = r_acc & NumIn;
      OP_OR:   w_res = r_acc | NumIn;
      OP_XOR:  w_res = r_acc ^ NumIn;
      OP_EQ:   w_res = {{(WIDTH-1){1'b0}}, (r_acc == NumIn)};
      OP_MUL:  w_res = NumIn;
      OP_LOAD: w_res = NumIn;
      default: w_res = r_acc;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_mul_start) w_state_next = ST_MUL;
      ST_MUL:  if (Clear || w_mul_done || !w_mul_busy) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= ST_IDLE;
      r_acc   <= '0;
      r_done  <= 1'b0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_done  <= 1'b0;
      if (Clear) begin
        r_acc   <= '0;
        r_carry <= 1'b0;
        r_ovf   <= 1'b0;
        r_zero  <= 1'b1;
      end else if (w_mul_done) begin
        r_acc   <= w_product[WIDTH-1:0];
        r_carry <= 1'b0;
        r_ovf   <= |w_product[2*WIDTH-1:WIDTH];
        r_zero  <= (w_product[WIDTH-1:0] == '0);
        r_done  <= 1'b1;
      end else if (w_accept && !w_is_mul) begin
        r_acc   <= w_res;
        r_carry <= w_carry;
        r_ovf   <= w_ovf;
        r_zero  <= (w_res == '0);
        r_done  <= 1'b1;
      end
    end
  end

  assign Ready    = (r_state == ST_IDLE);
  assign NumOut   = r_acc;
  assign Done     = r_done;
  assign Carry    = r_carry;
  assign Overflow = r_ovf;
  assign Zero     = r_zero;

endmodule
